// File: rtl/outport_fifo.sv
// outport_fifo: buffered multi-channel out-port, {ch, data} FIFO drained over valid/ready.
// Define OUTPORT_STICKY_OVF_EN to make overflow sticky until clear; otherwise it is a one-cycle pulse.
module outport_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CH_W   = 2
) (
  input  logic                       Clock,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          BusMuxOut,
  input  logic                       Outportin,
  input  logic [CH_W-1:0]            ch_sel,
  output logic [DATA_W-1:0]          dev_data,
  output logic [CH_W-1:0]            dev_ch,
  output logic                       dev_valid,
  input  logic                       dev_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DATA_W-1:0]          last_data,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [CH_W+DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop, push, drop;
  assign full      = count == CW'(DEPTH);
  assign empty     = count == '0;
  assign dev_valid = !empty;
  assign pop       = dev_valid && dev_ready;
  // a pop on the same edge frees the slot, so a full FIFO still accepts
  assign push      = Outportin && (!full || pop);
  assign drop      = Outportin && full && !pop;
  assign {dev_ch, dev_data} = mem[rd_ptr];
  always_ff @(posedge Clock)
    if (push) mem[wr_ptr] <= {ch_sel, BusMuxOut};
  always_ff @(posedge Clock or posedge clear)
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_data <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (push) last_data <= BusMuxOut;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
`ifdef OUTPORT_STICKY_OVF_EN
      overflow <= overflow | drop;
`else
      overflow <= drop;
`endif
    end
endmodule

// File: tb/tb_outport_fifo.sv
// tb_outport_fifo: table-driven directed checks plus wrap and mid-transfer reset sequences.
module tb_outport_fifo;
`ifdef OUTPORT_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic        Clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] BusMuxOut = '0;
  logic        Outportin = 1'b0;
  logic [1:0]  ch_sel = '0;
  logic [31:0] dev_data;
  logic [1:0]  dev_ch;
  logic        dev_valid;
  logic        dev_ready = 1'b0;
  logic        full, empty;
  logic [2:0]  count;
  logic [31:0] last_data;
  logic        overflow;
  int errors = 0;
  int checks = 0;

  outport_fifo dut (
    .Clock(Clock), .clear(clear), .BusMuxOut(BusMuxOut), .Outportin(Outportin),
    .ch_sel(ch_sel), .dev_data(dev_data), .dev_ch(dev_ch), .dev_valid(dev_valid),
    .dev_ready(dev_ready), .full(full), .empty(empty), .count(count),
    .last_data(last_data), .overflow(overflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int wr, d, ch, rdy;
    int cnt, hd, ed, ec, last, op, os;
  } vec_t;
  vec_t tv [11];

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_state(input string n, input int cnt);
    check({n, " count"}, 64'(count), 64'(cnt));
    check({n, " dev_valid"}, 64'(dev_valid), 64'(cnt != 0));
    check({n, " empty"}, 64'(empty), 64'(cnt == 0));
    check({n, " full"}, 64'(full), 64'(cnt == 4));
  endtask

  initial begin
    // fields: wr, d, ch, rdy | cnt, head-check, data, ch, last_data, ovf(pulse), ovf(sticky)
    tv[0]  = '{1, 'h11, 0, 0,  1, 1, 'h11, 0, 'h11, 0, 0};
    tv[1]  = '{1, 'h22, 1, 0,  2, 1, 'h11, 0, 'h22, 0, 0};
    tv[2]  = '{1, 'h33, 2, 0,  3, 1, 'h11, 0, 'h33, 0, 0};
    tv[3]  = '{1, 'h44, 3, 0,  4, 1, 'h11, 0, 'h44, 0, 0};
    tv[4]  = '{1, 'h55, 1, 0,  4, 1, 'h11, 0, 'h44, 1, 1};
    tv[5]  = '{0, 'h00, 0, 0,  4, 1, 'h11, 0, 'h44, 0, 1};
    tv[6]  = '{1, 'h66, 2, 1,  4, 1, 'h22, 1, 'h66, 0, 1};
    tv[7]  = '{0, 'h00, 0, 1,  3, 1, 'h33, 2, 'h66, 0, 1};
    tv[8]  = '{0, 'h00, 0, 1,  2, 1, 'h44, 3, 'h66, 0, 1};
    tv[9]  = '{0, 'h00, 0, 1,  1, 1, 'h66, 2, 'h66, 0, 1};
    tv[10] = '{0, 'h00, 0, 1,  0, 0, 'h00, 0, 'h66, 0, 1};

    // asynchronous reset mid-cycle, before any clock edge
    #2 clear = 1'b1;
    #1;
    check_state("reset", 0);
    check("reset last_data", 64'(last_data), 64'h0);
    check("reset overflow", 64'(overflow), 64'h0);
    step();
    clear = 1'b0;

    for (int i = 0; i < 11; i++) begin
      Outportin = tv[i].wr[0];
      BusMuxOut = tv[i].d;
      ch_sel    = tv[i].ch[1:0];
      dev_ready = tv[i].rdy[0];
      step();
      check_state($sformatf("vec%0d", i), tv[i].cnt);
      check($sformatf("vec%0d last_data", i), 64'(last_data), 64'(tv[i].last));
      check($sformatf("vec%0d overflow", i), 64'(overflow), 64'(STICKY ? tv[i].os : tv[i].op));
      if (tv[i].hd != 0) begin
        check($sformatf("vec%0d dev_data", i), 64'(dev_data), 64'(tv[i].ed));
        check($sformatf("vec%0d dev_ch", i), 64'(dev_ch), 64'(tv[i].ec));
      end
    end

    // pointer wrap: push+pop every cycle, head lags the write by one cycle
    dev_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Outportin = 1'b1;
      BusMuxOut = i;
      ch_sel    = 2'(i);
      step();
      check($sformatf("wrap%0d count", i), 64'(count), 64'd1);
      check($sformatf("wrap%0d dev_data", i), 64'(dev_data), 64'(i));
      check($sformatf("wrap%0d dev_ch", i), 64'(dev_ch), 64'(i % 4));
    end
    Outportin = 1'b0;
    step();
    check_state("wrap drain", 0);

    // reset mid-transfer with three entries pending and the head held
    dev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Outportin = 1'b1;
      BusMuxOut = 32'hA0 + i;
      ch_sel    = 2'(i);
      step();
    end
    Outportin = 1'b0;
    check_state("pre-clear", 3);
    check("pre-clear dev_data", 64'(dev_data), 64'hA0);
    #2 clear = 1'b1;
    #1;
    check_state("mid clear", 0);
    check("mid clear last_data", 64'(last_data), 64'h0);
    check("mid clear overflow", 64'(overflow), 64'h0);
    step();
    clear     = 1'b0;
    Outportin = 1'b1;
    BusMuxOut = 32'h77;
    ch_sel    = 2'd1;
    step();
    Outportin = 1'b0;
    check_state("post-clear push", 1);
    check("post-clear dev_data", 64'(dev_data), 64'h77);
    check("post-clear dev_ch", 64'(dev_ch), 64'd1);
    check("post-clear last_data", 64'(last_data), 64'h77);
    dev_ready = 1'b1;
    step();
    check_state("post-clear drain", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/outport_fifo.md
# outport_fifo

Buffered, multi-channel output port for the CPU datapath and the generalised successor to the single-register out-port. On an `out` instruction, the datapath asserts `Outportin` with the bus value and a channel number. The block enqueues that pair into a parameterised FIFO and drains it to an external device over a valid/ready handshake. The processor therefore never stalls on a slow peripheral unless the FIFO is full.

## Interface
Parameters:
- `DATA_W`, 32, width of the bus word and of each FIFO entry's data field
- `DEPTH`, 4, number of FIFO entries; power of two, ≥ 2
- `CH_W`, 2, channel-select width; 2^CH_W logical output channels

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge
- `clear`  in  1  asynchronous, active-high reset
- `BusMuxOut`  in  DATA_W  datapath bus value to be written
- `Outportin`  in  1  write strobe; one entry is offered per cycle while high
- `ch_sel`  in  CH_W  destination channel for the offered word
- `dev_data`  out  DATA_W  head-of-FIFO data
- `dev_ch`  out  CH_W  head-of-FIFO channel
- `dev_valid`  out  1  head entry valid; equals not-empty
- `dev_ready`  in  1  device accepts the head entry on a cycle where `dev_valid` is also high
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `count`  out  $clog2(DEPTH)+1  number of occupied entries
- `last_data`  out  DATA_W  most recent accepted write (legacy single-register out-port view)
- `overflow`  out  1  write dropped because the FIFO was full (see Configuration)

## Operation
- Storage: circular buffer of DEPTH entries, each {ch, data}. Write and read pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH. `count` is tracked separately.
- Pop: occurs when `dev_valid && dev_ready`. The read pointer advances and the count decrements.
- Push: occurs when `Outportin && (!full || pop)`. Entry {ch_sel, BusMuxOut} is written at the write pointer, the pointer advances, and the count increments.
- Simultaneous push and pop: the count is unchanged.
  - When full, the push is accepted because the pop frees a slot in the same edge.
  - When empty, pop cannot occur because `dev_valid` is 0. The push is accepted and the entry becomes visible on the next cycle; there is no bypass.
- Dropped write: `Outportin && full && !pop` discards the word. FIFO contents, pointers, count and `last_data` are unchanged, and `overflow` is asserted.
- `last_data`: loaded with `BusMuxOut` on every accepted push, independent of channel.
- Head outputs:
  - `dev_data` and `dev_ch` are driven combinationally from the entry at the read pointer.
  - They are stable while `dev_valid && !dev_ready`, as the handshake requires.
  - When empty, they show stale memory content, which is don't-care.
- Reset (`clear` = 1, at any time including mid-transfer): pointers = 0, count = 0, `last_data` = 0, `overflow` = 0. `empty` = 1, `full` = 0, `dev_valid` = 0. Memory contents are not cleared.

## Timing
- Write-to-visible latency: 1 cycle. A push at edge N gives `dev_valid` = 1 after edge N.
- Throughput: one push and one pop per cycle sustained.
- `full`, `empty`, `count` and `dev_valid` are functions of registered state only; they carry no combinational path from `Outportin`.
- `dev_ready` → push acceptance when full is a same-cycle combinational path. The device must drive `dev_ready` from registered logic.
- Device-side handshake: `dev_valid` never drops without a pop, except on `clear`.

## Configuration
- `OUTPORT_STICKY_OVF_EN`
  - Defined: `overflow` is sticky. It is set on the first dropped write and holds until `clear`.
  - Undefined: `overflow` is a registered single-cycle pulse, high for exactly the cycle after each dropped write.
  - Push/pop behaviour is identical in both builds.

## Test plan
- Reset then idle: `clear` pulse mid-cycle → `count` = 0, `empty` = 1, `dev_valid` = 0, `last_data` = 0 immediately (asynchronous reset).
- Fill/drain order (DEPTH=4, `dev_ready`=0):
  - Stimulus: push 0x11 ch0, 0x22 ch1, 0x33 ch2, 0x44 ch3.
  - Response: `full` = 1, `count` = 4.
  - Then raise `dev_ready`: outputs (0x11,0),(0x22,1),(0x33,2),(0x44,3) on consecutive cycles, then `empty` = 1.
- Overflow when full (`dev_ready`=0):
  - Stimulus: push 0x55.
  - Response: dropped, `count` stays 4, `last_data` stays 0x44.
  - With the macro: `overflow` stays 1.
  - Without it: `overflow` is high for one cycle only.
- Simultaneous push/pop when full: `dev_ready`=1 plus push 0x66 → 0x11 popped, 0x66 accepted, `count` stays 4, tail entry = 0x66.
- Pointer wrap: 10 back-to-back push+pop pairs with data 0..9 → `dev_data` sequence 0..9 with 1-cycle lag, `count` ≤ 1 throughout.
- Reset mid-transfer: `clear` asserted with `count` = 3 and `dev_valid` held → `count` = 0, `dev_valid` = 0. The next push of 0x77 is output as the first entry.
